// File: rtl/loop_cfg_issuer_if.sv
// Instruction-word stream between an instruction source and the loop issuer.
// Handshake: a word transfers on every rising clk edge where inst_valid and
// inst_ready are both high. While inst_valid is high and inst_ready is low,
// the master holds inst_data stable. inst_ready may be high with no word offered.
interface loop_cfg_issuer_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;

  modport master (output inst_valid, output inst_data, input inst_ready);
  modport slave  (input inst_valid, input inst_data, output inst_ready);
endinterface

// File: rtl/loop_cfg_issuer.sv
// Loop-instruction issuer: decodes LOOP_CFG words into per-group loop-bound
// config strobes and runs each block through start / wait-done / block_done.
module loop_cfg_issuer #(
  parameter int LOOP_ID_W   = 5,
  parameter int GROUP_ID_W  = 2,
  parameter int LOOP_ITER_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  loop_cfg_issuer_if.slave       inst,
  output logic                   cfg_loop_iter_v,
  output logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  output logic [LOOP_ID_W-1:0]   cfg_loop_iter_loop_id,
  output logic [GROUP_ID_W-1:0]  cfg_loop_group_id,
  output logic [GROUP_ID_W-1:0]  loop_group_id,
  output logic                   start,
  input  logic                   ctrl_done,
  output logic                   block_done,
  input  logic                   err_clear,
  output logic [2:0]             err_status,
  output logic [15:0]            block_count,
  output logic [1:0]             dbg_state
);

  localparam int NUM_GROUPS = 1 << GROUP_ID_W;
  localparam logic [LOOP_ID_W:0]   MAX_CNT  = {1'b1, {LOOP_ID_W{1'b0}}};
  localparam logic [LOOP_ID_W:0]   CNT_ONE  = {{LOOP_ID_W{1'b0}}, 1'b1};
  localparam logic [LOOP_ITER_W-1:0] ITER_ONE = {{(LOOP_ITER_W-1){1'b0}}, 1'b1};
  localparam logic [3:0] OP_LOOP_CFG  = 4'h1;
  localparam logic [3:0] OP_BLOCK_END = 4'h2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_CLOSE = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_inst_ready;
  logic                   r_cfg_v;
  logic [LOOP_ITER_W-1:0] r_cfg_iter;
  logic [LOOP_ID_W-1:0]   r_cfg_loop_id;
  logic [GROUP_ID_W-1:0]  r_cfg_group;
  logic [GROUP_ID_W-1:0]  r_loop_group_id;
  logic                   r_start;
  logic                   r_block_done;
  logic                   r_started;
  logic [2:0]             r_err;
  logic [15:0]            r_block_count;
  logic [LOOP_ID_W:0]     r_cnt [NUM_GROUPS];

  logic                   w_accept;
  logic [3:0]             w_opcode;
  logic [GROUP_ID_W-1:0]  w_group;
  logic [LOOP_ITER_W-1:0] w_trip;
  logic [LOOP_ITER_W-1:0] w_iter;
  logic [LOOP_ID_W:0]     w_grp_cnt;
  logic                   w_is_cfg;
  logic                   w_is_end;
  logic                   w_cfg_full;
  logic [2:0]             w_err_set;
  logic                   w_unused_bits;

  assign w_accept   = inst.inst_valid && r_inst_ready;
  assign w_opcode   = inst.inst_data[31:28];
  assign w_group    = inst.inst_data[21+GROUP_ID_W-1:21];
  assign w_trip     = inst.inst_data[LOOP_ITER_W-1:0];
  assign w_unused_bits = ^{inst.inst_data[27:21+GROUP_ID_W], inst.inst_data[20:LOOP_ITER_W]};
  assign w_grp_cnt  = r_cnt[w_group];
  assign w_is_cfg   = (w_opcode == OP_LOOP_CFG);
  assign w_is_end   = (w_opcode == OP_BLOCK_END);
  assign w_cfg_full = (w_grp_cnt == MAX_CNT);
  // A zero trip count is issued as a single iteration.
  assign w_iter     = (w_trip == '0) ? '0 : (w_trip - ITER_ONE);

  // Error events raised by the word accepted this cycle.
  always_comb begin
    w_err_set    = 3'b000;
    w_err_set[0] = w_accept && !w_is_cfg && !w_is_end;
    w_err_set[1] = w_accept && w_is_cfg && w_cfg_full;
    w_err_set[2] = w_accept && w_is_cfg && !w_cfg_full && (w_trip == '0);
  end

  // Issuer FSM with all outputs, per-group loop counts and sticky errors registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_inst_ready    <= 1'b1;
      r_cfg_v         <= 1'b0;
      r_cfg_iter      <= '0;
      r_cfg_loop_id   <= '0;
      r_cfg_group     <= '0;
      r_loop_group_id <= '0;
      r_start         <= 1'b0;
      r_block_done    <= 1'b0;
      r_started       <= 1'b0;
      r_err           <= 3'b000;
      r_block_count   <= 16'd0;
      for (int g = 0; g < NUM_GROUPS; g++) r_cnt[g] <= '0;
    end else begin
      r_cfg_v      <= 1'b0;
      r_start      <= 1'b0;
      r_block_done <= 1'b0;
      // New error events take priority over a simultaneous clear.
      r_err <= (err_clear ? 3'b000 : r_err) | w_err_set;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_cfg && !w_cfg_full) begin
              r_cfg_v          <= 1'b1;
              r_cfg_iter       <= w_iter;
              r_cfg_loop_id    <= w_grp_cnt[LOOP_ID_W-1:0];
              r_cfg_group      <= w_group;
              r_cnt[w_group]   <= w_grp_cnt + CNT_ONE;
            end else if (w_is_end) begin
              r_loop_group_id <= w_group;
              r_inst_ready    <= 1'b0;
              if (w_grp_cnt != '0) begin
                r_state   <= S_START;
                r_start   <= 1'b1;
                r_started <= 1'b1;
              end else begin
                // Nothing configured: close without launching the controller.
                r_state      <= S_CLOSE;
                r_block_done <= 1'b1;
                r_started    <= 1'b0;
              end
            end
          end
        end
        S_START: r_state <= S_RUN;
        S_RUN: begin
          if (ctrl_done) begin
            r_state      <= S_CLOSE;
            r_block_done <= 1'b1;
          end
        end
        S_CLOSE: begin
          r_state      <= S_IDLE;
          r_inst_ready <= 1'b1;
          r_started    <= 1'b0;
          if (r_started) r_block_count <= r_block_count + 16'd1;
          for (int g = 0; g < NUM_GROUPS; g++) r_cnt[g] <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst.inst_ready           = r_inst_ready;
  assign cfg_loop_iter_v           = r_cfg_v;
  assign cfg_loop_iter             = r_cfg_iter;
  assign cfg_loop_iter_loop_id     = r_cfg_loop_id;
  assign cfg_loop_group_id         = r_cfg_group;
  assign loop_group_id             = r_loop_group_id;
  assign start                     = r_start;
  assign block_done                = r_block_done;
  assign err_status                = r_err;
  assign block_count               = r_block_count;
  assign dbg_state                 = r_state;

endmodule
